// File: rtl/mpsoc_dbg_wb_burst_biu.sv
// Debug Wishbone burst bus interface unit: runs one command of up to
// MAX_BURST_LEN beats with byte-lane steering and valid/ready data flow control.
module mpsoc_dbg_wb_burst_biu #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16,
  parameter int TIMEOUT       = 1023,
  parameter int LEN_W         = $clog2(MAX_BURST_LEN) + 1
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]     cmd_adr_i,
  input  logic [3:0]                cmd_size_i,
  input  logic [LEN_W-1:0]          cmd_len_i,
  input  logic                      wdat_valid_i,
  output logic                      wdat_ready_o,
  input  logic [DATA_WIDTH-1:0]     wdat_i,
  output logic                      rdat_valid_o,
  input  logic                      rdat_ready_i,
  output logic [DATA_WIDTH-1:0]     rdat_o,
  output logic                      done_o,
  output logic [1:0]                status_o,
  output logic [LEN_W-1:0]          beats_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [ADDR_WIDTH-1:0]     wb_adr_o,
  output logic [DATA_WIDTH/8-1:0]   wb_sel_o,
  output logic [DATA_WIDTH-1:0]     wb_dat_o,
  input  logic [DATA_WIDTH-1:0]     wb_dat_i,
  output logic [2:0]                wb_cti_o,
  output logic [1:0]                wb_bte_o,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i
);

  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [2:0] {IDLE, CHECK, WDATA, BUS, RHOLD, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [3:0]              size_q, size_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        beats_q, beats_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
  logic [1:0]              status_q, status_d;
  logic [31:0]             to_q, to_d;

  logic [OFFW-1:0]         off;
  logic [NB-1:0]           sel;
  logic [DATA_WIDTH-1:0]   wrep;
  logic [DATA_WIDTH-1:0]   rshift;
  logic [DATA_WIDTH-1:0]   rlane;
  logic [LEN_W-1:0]        remaining;
  logic                    full_word, last_ack, cmd_bad, bus;
  logic [2:0]              cti;

  assign off       = adr_q[OFFW-1:0];
  assign full_word = (32'(size_q) == NB);
  assign remaining = len_q - beats_q;
  assign last_ack  = ((beats_q + LEN_W'(1)) == len_q);
  assign bus       = (state_q == BUS);

  assign cmd_bad = !((size_q == 4'd1) || (size_q == 4'd2) || (size_q == 4'd4) || (size_q == 4'd8))
                || (32'(size_q) > NB)
                || ((adr_q[2:0] & (size_q[2:0] - 3'd1)) != 3'd0)
                || (len_q == '0)
                || (len_q > LEN_W'(MAX_BURST_LEN));

  // Lane steering: select mask, write replication and read extraction.
  always_comb begin
    sel  = '0;
    wrep = '0;
    rlane = '0;
    rshift = wb_dat_i >> {off, 3'b000};
    for (int unsigned i = 0; i < NB; i++) begin
      sel[i +: 1] = (i >= 32'(off)) && (i < 32'(off) + 32'(size_q));
      case (size_q)
        4'd1:    wrep[8*i +: 8] = wdat_i[7:0];
        4'd2:    wrep[8*i +: 8] = wdat_i[8*(i%2) +: 8];
        4'd4:    wrep[8*i +: 8] = wdat_i[8*(i%4) +: 8];
        default: wrep[8*i +: 8] = wdat_i[8*(i%8) +: 8];
      endcase
      if (i < 32'(size_q)) rlane[8*i +: 8] = rshift[8*i +: 8];
    end
  end

  always_comb begin
    cti = 3'b000;
    if (full_word && remaining >= LEN_W'(2))                     cti = 3'b010;
    else if (full_word && len_q > LEN_W'(1) && remaining == LEN_W'(1)) cti = 3'b111;
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    adr_d        = adr_q;
    size_d       = size_q;
    len_d        = len_q;
    beats_d      = beats_q;
    wdat_d       = wdat_q;
    rdat_d       = rdat_q;
    status_d     = status_q;
    to_d         = '0;
    wdat_ready_o = 1'b0;
    rdat_valid_o = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          we_d     = cmd_we_i;
          adr_d    = cmd_adr_i;
          size_d   = cmd_size_i;
          len_d    = cmd_len_i;
          beats_d  = '0;
          status_d = 2'b00;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (cmd_bad) begin
          status_d = 2'b11;
          state_d  = DONE;
        end else begin
          state_d = we_q ? WDATA : BUS;
        end
      end
      WDATA: begin
        wdat_ready_o = 1'b1;
        if (wdat_valid_i) begin
          wdat_d  = wrep;
          state_d = BUS;
        end
      end
      BUS: begin
        // err wins over a simultaneous ack; the beat is not counted.
        if (wb_err_i) begin
          status_d = 2'b01;
          state_d  = DONE;
        end else if (wb_ack_i) begin
          beats_d = beats_q + LEN_W'(1);
          adr_d   = adr_q + ADDR_WIDTH'(size_q);
          if (!we_q) begin
            rdat_d  = rlane;
            state_d = RHOLD;
          end else if (last_ack) begin
            status_d = 2'b00;
            state_d  = DONE;
          end else begin
            state_d = WDATA;
          end
        end else if (TIMEOUT != 0 && to_q == 32'(TIMEOUT - 1)) begin
          status_d = 2'b10;
          state_d  = DONE;
        end else begin
          to_d = to_q + 32'd1;
        end
      end
      RHOLD: begin
        rdat_valid_o = 1'b1;
        if (rdat_ready_i) begin
          if (beats_q == len_q) begin
            status_d = 2'b00;
            state_d  = DONE;
          end else begin
            state_d = BUS;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      adr_q    <= '0;
      size_q   <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      status_q <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      size_q   <= size_d;
      len_q    <= len_d;
      beats_q  <= beats_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      status_q <= status_d;
      to_q     <= to_d;
    end
  end

  // Ready is masked during reset so every output reads zero at the reset edge.
  assign cmd_ready_o = (state_q == IDLE) && !wb_rst_i;
  assign rdat_o      = rdat_q;
  assign status_o    = status_q;
  assign beats_o     = beats_q;
  assign wb_cyc_o    = bus;
  assign wb_stb_o    = bus;
  assign wb_we_o     = bus && we_q;
  assign wb_adr_o    = bus ? (adr_q & ~ADDR_WIDTH'(NB - 1)) : '0;
  assign wb_sel_o    = bus ? sel : '0;
  assign wb_dat_o    = (bus && we_q) ? wdat_q : '0;
  assign wb_cti_o    = bus ? cti : 3'b000;
  assign wb_bte_o    = 2'b00;

endmodule
